// File: rtl/transducer_array_output_if.sv
// Arm/fire handshake and status shared between the config block and the transducer bank.
interface transducer_array_output_if;
   logic arm;
   logic fire;
   logic abort;
   logic clear_fault;
   logic fire_complete;
   logic busy;
   logic fault;

   modport master (output arm, fire, abort, clear_fault,
                   input  fire_complete, busy, fault);
   modport slave  (input  arm, fire, abort, clear_fault,
                   output fire_complete, busy, fault);
endinterface

// File: rtl/transducer_array_output.sv
// Multi-channel transducer gate driver: per-channel phase delay and charge time,
// shared pulse burst, per-channel on-time watchdog latching a fault.
module transducer_array_output #(
   parameter int unsigned N_CH   = 8,
   parameter int unsigned PD_W   = 16,
   parameter int unsigned CT_W   = 9,
   parameter int unsigned NP_W   = 8,
   parameter int unsigned MAX_ON = 512
) (
   input  logic                   clk,
   input  logic                   rst,
   transducer_array_output_if.slave hs,
   input  logic [N_CH-1:0]        ch_enable,
   input  logic [N_CH*PD_W-1:0]   phase_delay,
   input  logic [N_CH*CT_W-1:0]   charge_time,
   input  logic [CT_W-1:0]        off_time,
   input  logic [NP_W-1:0]        n_pulses,
   output logic [N_CH-1:0]        tx_out,
   output logic [N_CH-1:0]        warning
);
   localparam int unsigned     CNT_W    = (PD_W > CT_W) ? PD_W : CT_W;
   localparam int unsigned     WD_W     = CT_W + 1;
   localparam logic [WD_W-1:0] MAX_ON_V = WD_W'(MAX_ON);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_FIRING, S_DONE, S_FAULT} state_t;
   typedef enum logic [1:0] {C_DELAY, C_ON, C_OFF, C_DONE} ch_state_t;

   state_t           state_q, state_d;
   ch_state_t        sub_q [N_CH];
   ch_state_t        sub_d [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [NP_W-1:0]  pl_q  [N_CH];
   logic [NP_W-1:0]  pl_d  [N_CH];
   logic [CT_W-1:0]  ct_q  [N_CH];
   logic [CT_W-1:0]  ct_d  [N_CH];
   logic [WD_W-1:0]  wd_q  [N_CH];
   logic [WD_W-1:0]  wd_d  [N_CH];
   logic [CT_W-1:0]  off_q, off_d;
   logic [N_CH-1:0]  tx_q, tx_d, warning_q, warning_d, trip;
   logic             fire_complete_q, fire_complete_d;
   logic             busy_q, busy_d, fault_q, fault_d;
   logic             all_done;
   logic [PD_W-1:0]  pd_in;
   logic [CT_W-1:0]  ct_in;

   function automatic logic [CNT_W-1:0] ct_m1(input logic [CT_W-1:0] v);
      logic [CT_W-1:0] t;
      t = v - 1'b1;
      return CNT_W'(t);
   endfunction

   function automatic logic [CNT_W-1:0] pd_m1(input logic [PD_W-1:0] v);
      logic [PD_W-1:0] t;
      t = v - 1'b1;
      return CNT_W'(t);
   endfunction

   always_comb begin
      state_d   = state_q;
      sub_d     = sub_q;
      cnt_d     = cnt_q;
      pl_d      = pl_q;
      ct_d      = ct_q;
      off_d     = off_q;
      warning_d = warning_q;
      pd_in     = '0;
      ct_in     = '0;
      all_done  = 1'b1;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (sub_q[i] != C_DONE) all_done = 1'b0;
         trip[i] = (wd_q[i] == MAX_ON_V);
      end

      unique case (state_q)
         S_IDLE: if (!hs.abort && hs.arm) state_d = S_ARMED;
         S_ARMED: begin
            off_d = off_time;
            for (int unsigned i = 0; i < N_CH; i++) ct_d[i] = charge_time[i*CT_W +: CT_W];
            if (hs.abort || !hs.arm) begin
               state_d = S_IDLE;
            end else if (hs.fire) begin
               state_d = S_FIRING;
               // Channels start from the live inputs: these are the values captured on this edge.
               for (int unsigned i = 0; i < N_CH; i++) begin
                  pd_in   = phase_delay[i*PD_W +: PD_W];
                  ct_in   = charge_time[i*CT_W +: CT_W];
                  pl_d[i] = n_pulses - 1'b1;
                  if (!ch_enable[i] || ct_in == '0 || n_pulses == '0) begin
                     sub_d[i] = C_DONE;
                     cnt_d[i] = '0;
                     pl_d[i]  = '0;
                  end else if (pd_in == '0) begin
                     sub_d[i] = C_ON;
                     cnt_d[i] = ct_m1(ct_in);
                  end else begin
                     sub_d[i] = C_DELAY;
                     cnt_d[i] = pd_m1(pd_in);
                  end
               end
            end
         end
         S_FIRING: begin
            if (|trip) begin
               state_d   = S_FAULT;
               warning_d = warning_q | trip;
            end else if (hs.abort) begin
               state_d = S_IDLE;
            end else if (all_done) begin
               state_d = S_DONE;
            end else begin
               // cnt holds the cycles remaining in the current sub-state after this one.
               for (int unsigned i = 0; i < N_CH; i++) begin
                  unique case (sub_q[i])
                     C_DELAY, C_OFF: begin
                        if (cnt_q[i] == '0) begin
                           sub_d[i] = C_ON;
                           cnt_d[i] = ct_m1(ct_q[i]);
                        end else begin
                           cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                     end
                     C_ON: begin
                        if (cnt_q[i] != '0) begin
                           cnt_d[i] = cnt_q[i] - 1'b1;
                        end else if (pl_q[i] == '0) begin
                           sub_d[i] = C_DONE;
                        end else begin
                           pl_d[i] = pl_q[i] - 1'b1;
                           if (off_q == '0) begin
                              cnt_d[i] = ct_m1(ct_q[i]);
                           end else begin
                              sub_d[i] = C_OFF;
                              cnt_d[i] = ct_m1(off_q);
                           end
                        end
                     end
                     default: sub_d[i] = C_DONE;
                  endcase
               end
            end
         end
         S_DONE: if (hs.abort || (!hs.arm && !hs.fire)) state_d = S_IDLE;
         S_FAULT: begin
            if (hs.clear_fault && !hs.arm) begin
               state_d   = S_IDLE;
               warning_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      for (int unsigned i = 0; i < N_CH; i++) begin
         if (state_d != S_FIRING) begin
            sub_d[i] = C_DONE;
            cnt_d[i] = '0;
            pl_d[i]  = '0;
         end
         tx_d[i] = (state_d == S_FIRING) && (sub_d[i] == C_ON);
         wd_d[i] = tx_d[i] ? wd_q[i] + 1'b1 : '0;
      end
      fire_complete_d = (state_d == S_DONE) || (state_d == S_FAULT);
      busy_d          = (state_d == S_ARMED) || (state_d == S_FIRING);
      fault_d         = (state_d == S_FAULT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         off_q           <= '0;
         tx_q            <= '0;
         warning_q       <= '0;
         fire_complete_q <= 1'b0;
         busy_q          <= 1'b0;
         fault_q         <= 1'b0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            sub_q[i] <= C_DONE;
            cnt_q[i] <= '0;
            pl_q[i]  <= '0;
            ct_q[i]  <= '0;
            wd_q[i]  <= '0;
         end
      end else begin
         state_q         <= state_d;
         off_q           <= off_d;
         tx_q            <= tx_d;
         warning_q       <= warning_d;
         fire_complete_q <= fire_complete_d;
         busy_q          <= busy_d;
         fault_q         <= fault_d;
         for (int unsigned i = 0; i < N_CH; i++) begin
            sub_q[i] <= sub_d[i];
            cnt_q[i] <= cnt_d[i];
            pl_q[i]  <= pl_d[i];
            ct_q[i]  <= ct_d[i];
            wd_q[i]  <= wd_d[i];
         end
      end
   end

   assign tx_out           = tx_q;
   assign warning          = warning_q;
   assign hs.fire_complete = fire_complete_q;
   assign hs.busy          = busy_q;
   assign hs.fault         = fault_q;
endmodule

// File: tb/tb_transducer_array_output.sv
// Scoreboard bench for transducer_array_output: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_transducer_array_output;
   localparam int unsigned N_CH   = 4;
   localparam int unsigned PD_W   = 16;
   localparam int unsigned CT_W   = 10;
   localparam int unsigned NP_W   = 8;
   localparam int unsigned MAX_ON = 512;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N_CH-1:0]      ch_enable;
   logic [N_CH*PD_W-1:0] phase_delay;
   logic [N_CH*CT_W-1:0] charge_time;
   logic [CT_W-1:0]      off_time;
   logic [NP_W-1:0]      n_pulses;
   logic [N_CH-1:0]      tx_out;
   logic [N_CH-1:0]      warning;

   transducer_array_output_if hs ();

   transducer_array_output #(
      .N_CH(N_CH), .PD_W(PD_W), .CT_W(CT_W), .NP_W(NP_W), .MAX_ON(MAX_ON)
   ) dut (
      .clk(clk), .rst(rst), .hs(hs), .ch_enable(ch_enable),
      .phase_delay(phase_delay), .charge_time(charge_time), .off_time(off_time),
      .n_pulses(n_pulses), .tx_out(tx_out), .warning(warning)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         tag;
      string      name;
      logic [3:0] tx;
      logic       fc;
      logic       busy;
      logic       fault;
      logic [3:0] warn;
   } exp_t;

   exp_t sbq[$];
   exp_t m;
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;
   int   pd_v[4];
   int   ct_v[4];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void cmp(input exp_t e);
      n_total++;
      if (e.tag == cyc && tx_out === e.tx && hs.fire_complete === e.fc &&
          hs.busy === e.busy && hs.fault === e.fault && warning === e.warn)
         n_pass++;
      else
         $display("FAIL %s cyc=%0d tag=%0d: got tx=%b fc=%b busy=%b fault=%b warn=%b, want tx=%b fc=%b busy=%b fault=%b warn=%b",
                  e.name, cyc, e.tag, tx_out, hs.fire_complete, hs.busy, hs.fault, warning,
                  e.tx, e.fc, e.busy, e.fault, e.warn);
   endfunction

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
         m = sbq.pop_front();
         cmp(m);
      end
   end

   // Queue the outputs expected after the next clock edge, then wait for that cycle.
   task automatic step(input string name, input logic [3:0] tx, input logic fc,
                       input logic busy, input logic fault, input logic [3:0] warn);
      exp_t e;
      e.tag = cyc + 1; e.name = name; e.tx = tx; e.fc = fc;
      e.busy = busy; e.fault = fault; e.warn = warn;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   function automatic logic [3:0] model_tx(input int c, input logic [3:0] en,
                                           input int off, input int np);
      logic [3:0] r;
      int s;
      r = '0;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < np; k++) begin
            s = pd_v[i] + k * (ct_v[i] + off);
            if (en[i] && c >= s && c < s + ct_v[i]) r[i] = 1'b1;
         end
      return r;
   endfunction

   task automatic fire_run(input string name, input logic [3:0] en, input int off,
                           input int np, input bit simul, input int abort_at, input int rst_at);
      int last, trip_c, d, t;
      logic [3:0] twarn;
      exp_t e;
      ch_enable = en;
      off_time  = CT_W'(off);
      n_pulses  = NP_W'(np);
      for (int i = 0; i < 4; i++) begin
         phase_delay[i*PD_W +: PD_W] = PD_W'(pd_v[i]);
         charge_time[i*CT_W +: CT_W] = CT_W'(ct_v[i]);
      end
      last = -1; trip_c = -1; twarn = '0;
      for (int i = 0; i < 4; i++)
         if (en[i] && ct_v[i] > 0 && np > 0) begin
            t = pd_v[i] + (np - 1) * (ct_v[i] + off) + ct_v[i] - 1;
            if (t > last) last = t;
            if (ct_v[i] >= int'(MAX_ON)) begin
               t = pd_v[i] + int'(MAX_ON);
               if (trip_c < 0 || t < trip_c) begin trip_c = t; twarn = '0; end
               if (t == trip_c) twarn[i] = 1'b1;
            end
         end
      d = (last < 0) ? 1 : last + 2;
      hs.arm  = 1'b1;
      hs.fire = simul;
      step({name, ":armed"}, 4'b0, 1'b0, 1'b1, 1'b0, 4'b0);
      hs.fire = 1'b1;
      for (int c = 0; c <= d + 2; c++) begin
         if (c == 1) hs.arm = 1'b0;
         if (abort_at >= 0 && c == abort_at + 1) begin
            hs.abort = 1'b1;
            step({name, ":abort"}, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
            hs.abort = 1'b0;
            hs.fire  = 1'b0;
            return;
         end
         if (rst_at >= 0 && c == rst_at) begin
            #1 rst = 1'b0;
            #1;
            e.tag = cyc; e.name = {name, ":async_rst"}; e.tx = '0; e.fc = 1'b0;
            e.busy = 1'b0; e.fault = 1'b0; e.warn = '0;
            cmp(e);
            step({name, ":rst_hold"}, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
            rst = 1'b1;
            step({name, ":fire_no_arm"}, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
            hs.fire = 1'b0;
            step({name, ":idle"}, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
            return;
         end
         if (c == trip_c) begin
            step({name, ":trip"}, 4'b0, 1'b1, 1'b0, 1'b1, twarn);
            return;
         end
         if (c < d) begin
            step($sformatf("%s:c%0d", name, c), model_tx(c, en, off, np), 1'b0, 1'b1, 1'b0, 4'b0);
         end else if (c <= d + 1) begin
            step($sformatf("%s:done%0d", name, c - d), 4'b0, 1'b1, 1'b0, 1'b0, 4'b0);
         end else begin
            hs.fire = 1'b0;
            step({name, ":idle"}, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      hs.arm = 1'b0; hs.fire = 1'b0; hs.abort = 1'b0; hs.clear_fault = 1'b0;
      ch_enable = '0; phase_delay = '0; charge_time = '0; off_time = '0; n_pulses = '0;
      @(negedge clk);
      step("reset", 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
      rst = 1'b1;
      hs.fire = 1'b1;
      step("fire_no_arm", 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
      hs.fire = 1'b0;

      pd_v = '{0, 3, 10, 65535}; ct_v = '{5, 5, 5, 5};
      fire_run("main", 4'hF, 0, 1, 1'b0, -1, -1);

      pd_v = '{2, 0, 0, 0}; ct_v = '{4, 0, 0, 0};
      fire_run("burst", 4'b0001, 3, 3, 1'b0, -1, -1);

      pd_v = '{1, 0, 2, 0}; ct_v = '{2, 3, 1, 0};
      fire_run("simul", 4'hF, 1, 2, 1'b1, -1, -1);

      pd_v = '{0, 1, 2, 3}; ct_v = '{5, 5, 5, 5};
      fire_run("en0", 4'h0, 0, 1, 1'b0, -1, -1);
      fire_run("np0", 4'hF, 0, 0, 1'b0, -1, -1);

      pd_v = '{0, 3, 10, 20}; ct_v = '{5, 5, 5, 5};
      fire_run("abort", 4'hF, 0, 1, 1'b0, 6, -1);
      fire_run("replay", 4'hF, 0, 1, 1'b0, -1, -1);

      pd_v = '{0, 1, 2, 3}; ct_v = '{511, 3, 3, 3};
      fire_run("ct511", 4'hF, 0, 1, 1'b0, -1, -1);

      pd_v = '{0, 1, 4, 3}; ct_v = '{3, 3, 512, 3};
      fire_run("ct512", 4'hF, 0, 1, 1'b0, -1, -1);
      hs.arm = 1'b1; hs.fire = 1'b1;
      step("fault_armfire", 4'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
      hs.abort = 1'b1;
      step("fault_abort", 4'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
      hs.abort = 1'b0; hs.clear_fault = 1'b1;
      step("fault_clear_armed", 4'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
      hs.arm = 1'b0; hs.fire = 1'b0;
      step("fault_clear", 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);
      hs.clear_fault = 1'b0;
      step("post_clear", 4'b0, 1'b0, 1'b0, 1'b0, 4'b0);

      pd_v = '{2, 0, 0, 0}; ct_v = '{4, 0, 0, 0};
      fire_run("burst_rst", 4'b0001, 3, 3, 1'b0, -1, 11);
      pd_v = '{0, 0, 0, 0}; ct_v = '{2, 0, 0, 0};
      fire_run("after_rst", 4'b0001, 0, 1, 1'b0, -1, -1);

      repeat (2) @(negedge clk);
      if (sbq.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sbq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
